// File: rtl/edge_detect_multi.sv
// edge_detect_multi: multi-channel synchroniser, debounce filter and edge
// tick generator with sticky event flags and an aggregated interrupt.
// Each channel is independent. The debounced level only moves after DEBOUNCE
// consecutive cycles in which the synchronised input disagrees with it. That
// update edge is the only place a tick can be produced, so changing mode
// cannot create a tick on its own.
module edge_detect_multi #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     clr,
    output logic [WIDTH-1:0]     tick,
    output logic [WIDTH-1:0]     level,
    output logic [WIDTH-1:0]     flag,
    output logic                 irq
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]                  level_q, level_d;
    logic [WIDTH-1:0]                  tick_q, tick_d;
    logic [WIDTH-1:0]                  flag_q, flag_d;
    logic [WIDTH-1:0]                  s;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift raw inputs through the synchroniser chain; stage 0 faces the pins.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in};
    end

    // Debounce counters, level update, mode-qualified tick and sticky flags.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        tick_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = s[i];
                cnt_d[i]   = '0;
                // Rising edges use the low mode bit, falling edges the high one.
                tick_d[i]  = s[i] ? mode[2*i] : mode[2*i+1];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        // A new event takes priority over a clear arriving in the same cycle.
        flag_d = (flag_q & ~clr) | tick_d;
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            tick_q  <= '0;
            flag_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            tick_q  <= tick_d;
            flag_q  <= flag_d;
        end
    end

    assign tick  = tick_q;
    assign level = level_q;
    assign flag  = flag_q;
    assign irq   = |flag_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: directed stimulus, a windowed behavioural
// model checked every cycle, and literal expectations at key points.
module tb_edge_detect_multi;

    localparam int W    = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in = '0;
    logic [2*W-1:0] mode = 8'h55;
    logic [W-1:0] clr = '0;
    logic [W-1:0] tick, level, flag;
    logic         irq;

    int checks = 0;
    int errors = 0;

    edge_detect_multi #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .mode(mode), .clr(clr),
        .tick(tick), .level(level), .flag(flag), .irq(irq)
    );

    always #5 clk = ~clk;

    // Model: history of captured inputs; a channel's level flips when the
    // last DEB synchronised samples all disagree with it.
    logic [W-1:0] cap [0:15] = '{default: '0};
    logic [W-1:0] m_level = '0;
    logic [W-1:0] m_tick  = '0;
    logic [W-1:0] m_flag  = '0;
    logic [W-1:0] nt;
    bit           all_diff;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) cap[k] = '0;
            m_level = '0;
            m_tick  = '0;
            m_flag  = '0;
        end else begin
            nt = '0;
            for (int c = 0; c < W; c++) begin
                all_diff = 1'b1;
                for (int j = SYNC - 1; j < SYNC - 1 + DEB; j++)
                    if (cap[j][c] == m_level[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[c] = ~m_level[c];
                    nt[c] = m_level[c] ? mode[2*c] : mode[2*c+1];
                end
            end
            m_tick = nt;
            m_flag = (m_flag & ~clr) | nt;
            for (int k = 15; k > 0; k--) cap[k] = cap[k-1];
            cap[0] = in;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_tick",  8'(tick),  8'(m_tick));
        chk("model_level", 8'(level), 8'(m_level));
        chk("model_flag",  8'(flag),  8'(m_flag));
        chk("model_irq",   8'(irq),   8'(|m_flag));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_tick", 8'(tick), 8'h0);
        chk("rst_level", 8'(level), 8'h0);
        chk("rst_flag", 8'(flag), 8'h0);
        chk("rst_irq", 8'(irq), 8'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Channel 0 rising, all channels in rising mode
        in = 4'b0001;
        repeat (5) @(posedge clk);
        @(negedge clk); chk("t1_tick_before", 8'(tick), 8'h0);
        @(posedge clk); @(negedge clk); chk("t1_tick", 8'(tick), 8'h1);
        @(posedge clk); @(negedge clk); chk("t1_tick_after", 8'(tick), 8'h0);
        chk("t1_level", 8'(level), 8'h1);
        chk("t1_flag", 8'(flag), 8'h1);
        chk("t1_irq", 8'(irq), 8'h1);
        cyc(1);

        // Channel 1 falling-only
        mode = 8'h59;
        in = 4'b0011;
        cyc(10);
        chk("t2_level_hi", 8'(level), 8'h3);
        chk("t2_flag_norise", 8'(flag), 8'h1);
        in = 4'b0001;
        repeat (6) @(posedge clk);
        @(negedge clk); chk("t2_fall_tick", 8'(tick), 8'h2);
        chk("t2_flag", 8'(flag), 8'h3);
        chk("t2_level_lo", 8'(level), 8'h1);
        cyc(3);

        // Channel 2 glitch of 3 cycles, then a 4-cycle pulse, both-edge mode
        mode = 8'h79;
        in = 4'b0101;
        cyc(3);
        in = 4'b0001;
        cyc(10);
        chk("t3_glitch_level", 8'(level), 8'h1);
        chk("t3_glitch_flag", 8'(flag), 8'h3);
        in = 4'b0101;
        cyc(4);
        in = 4'b0001;
        repeat (2) @(posedge clk);
        @(negedge clk); chk("t3_rise_tick", 8'(tick), 8'h4);
        chk("t3_rise_level", 8'(level), 8'h5);
        repeat (4) @(posedge clk);
        @(negedge clk); chk("t3_fall_tick", 8'(tick), 8'h4);
        chk("t3_fall_level", 8'(level), 8'h1);
        chk("t3_flag", 8'(flag), 8'h7);
        cyc(3);

        // Sticky flag: clear collides with a new ch0 tick, then clear alone
        in = 4'b0000;
        cyc(10);
        in = 4'b0001;
        cyc(5);
        clr = 4'b0001;
        cyc(1);
        clr = 4'b0000;
        @(negedge clk); chk("t4_tick", 8'(tick), 8'h1);
        chk("t4_set_wins", 8'(flag), 8'h7);
        cyc(1);
        clr = 4'b0001;
        cyc(1);
        clr = 4'b0000;
        @(negedge clk); chk("t4_clr0", 8'(flag), 8'h6);
        cyc(1);
        clr = 4'b1110;
        cyc(1);
        clr = 4'b0000;
        @(negedge clk); chk("t4_clr_all", 8'(flag), 8'h0);
        chk("t4_irq", 8'(irq), 8'h0);
        cyc(1);

        // Mode off: level tracks, no ticks or flags; mode change alone is silent
        mode = 8'h00;
        in = 4'hF;
        cyc(10);
        chk("t5_level_hi", 8'(level), 8'hF);
        in = 4'h0;
        cyc(10);
        chk("t5_level_lo", 8'(level), 8'h0);
        in = 4'hA;
        cyc(10);
        in = 4'hF;
        cyc(10);
        chk("t5_flag", 8'(flag), 8'h0);
        mode = 8'hFF;
        cyc(10);
        chk("t5_modechg_flag", 8'(flag), 8'h0);

        // Reset in the middle of a debounce window
        mode = 8'h55;
        in = 4'h0;
        cyc(10);
        in = 4'hF;
        cyc(2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_level", 8'(level), 8'h0);
        chk("t6_rst_tick", 8'(tick), 8'h0);
        chk("t6_rst_irq", 8'(irq), 8'h0);
        cyc(2);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk); chk("t6_tick_before", 8'(tick), 8'h0);
        @(posedge clk); @(negedge clk); chk("t6_tick", 8'(tick), 8'hF);
        @(posedge clk); @(negedge clk); chk("t6_tick_after", 8'(tick), 8'h0);
        chk("t6_flag", 8'(flag), 8'hF);
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
